stream_upsizer: RTL and testbench

Valid/ready width up-converter. It packs RATIO consecutive narrow beats into one wide word and sits directly upstream of the elastic register pipeline, feeding its data input with IN_WIDTH*RATIO-bit words. It lets narrow producers (byte-wide units, serial front ends) drive the wide datapath at full throughput while keeping the same handshake semantics end to end. An optional last-beat flush emits partially filled words with a lane mask.

---
 rtl/stream_upsizer.sv | 145 ++++++++++++++
 tb/tb_stream_upsizer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsizer.sv
// stream_upsizer: valid/ready width up-converter.
//
// Packs RATIO consecutive IN_WIDTH-bit beats into one IN_WIDTH*RATIO-bit word.
// The first accepted beat of a word lands in lane 0 (LSBs) and later beats fill
// increasing lanes. The beat that fills the top lane closes the word. It is
// written straight into the output register together with the RATIO-1
// accumulated lanes, so only RATIO-1 lanes need accumulator storage.
//
// Optional feature (macro STREAM_UPSIZER_LAST_EN):
//   defined   - data_in_last closes a word early. Lanes above the closing beat
//               are zeroed, data_out_mask flags the filled lanes and
//               data_out_last is set. Because any beat may close a word,
//               data_in_ready = out_free.
//   undefined - data_in_last is ignored. Every word is full, data_out_mask is
//               all-ones whenever valid, and data_out_last is always 0.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   data_in        narrow input beat
//   data_in_valid  input beat offered
//   data_in_last   beat closes the current word early (feature build only)
//   data_in_ready  input beat accepted when valid && ready
//   data_out       packed word, lane i = bits [i*IN_WIDTH +: IN_WIDTH]
//   data_out_mask  bit i set = lane i holds a real beat
//   data_out_last  word was closed by data_in_last
//   data_out_valid word offered
//   data_out_ready word consumed when valid && ready

module stream_upsizer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [IN_WIDTH-1:0]          data_in,
    input  logic                         data_in_valid,
    input  logic                         data_in_last,
    output logic                         data_in_ready,
    output logic [IN_WIDTH*RATIO-1:0]    data_out,
    output logic [RATIO-1:0]             data_out_mask,
    output logic                         data_out_last,
    output logic                         data_out_valid,
    input  logic                         data_out_ready
);

    localparam int unsigned OutW = IN_WIDTH * RATIO;
    localparam int unsigned AccW = IN_WIDTH * (RATIO - 1);
    localparam int unsigned CntW = $clog2(RATIO);
    localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [OutW-1:0]  out_data_q, out_data_d;
    logic [RATIO-1:0] out_mask_q, out_mask_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;

    logic             out_free;
    logic             accept;
    logic             close_beat;
    logic             in_last;
    // Accumulator padded to the full output width so every lane index is in range.
    logic [OutW-1:0]  acc_ext;

    assign out_free = !out_valid_q || data_out_ready;

`ifdef STREAM_UPSIZER_LAST_EN
    assign in_last       = data_in_last;
    assign data_in_ready = out_free;
`else
    logic unused_data_in_last;
    assign unused_data_in_last = data_in_last;
    assign in_last             = 1'b0;
    // Non-closing beats only touch the accumulator, so they never wait on the output.
    assign data_in_ready       = (cnt_q != CntMax) || out_free;
`endif

    assign accept     = data_in_valid && data_in_ready;
    assign close_beat = (cnt_q == CntMax) || in_last;
    assign acc_ext    = {{IN_WIDTH{1'b0}}, acc_q};

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        // Consumption frees the register; a same-edge load below overrides it.
        if (out_valid_q && data_out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (close_beat) begin
                for (int i = 0; i < int'(RATIO); i++) begin
                    if (i < int'(cnt_q)) begin
                        out_data_d[i*IN_WIDTH +: IN_WIDTH] = acc_ext[i*IN_WIDTH +: IN_WIDTH];
                    end else if (i == int'(cnt_q)) begin
                        out_data_d[i*IN_WIDTH +: IN_WIDTH] = data_in;
                    end else begin
                        out_data_d[i*IN_WIDTH +: IN_WIDTH] = '0;
                    end
                    out_mask_d[i] = (i <= int'(cnt_q));
                end
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                for (int i = 0; i < int'(RATIO) - 1; i++) begin
                    if (CntW'(i) == cnt_q) begin
                        acc_d[i*IN_WIDTH +: IN_WIDTH] = data_in;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out       = out_data_q;
    assign data_out_mask  = out_mask_q;
    assign data_out_last  = out_last_q;
    assign data_out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Testbench for stream_upsizer (IN_WIDTH=8, RATIO=4). Table-driven directed
// vectors, hand-written backpressure and early-close sequences, and a
// randomised run against a small packing model. Works with and without
// STREAM_UPSIZER_LAST_EN defined.

module tb_stream_upsizer;

`ifdef STREAM_UPSIZER_LAST_EN
    localparam bit LastEn = 1'b1;
`else
    localparam bit LastEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        vin;
    logic        lin;
    logic        irdy;
    logic [31:0] dout;
    logic [3:0]  mask;
    logic        olast;
    logic        ov;
    logic        ordy;

    int checks = 0;
    int errors = 0;

    stream_upsizer #(
        .IN_WIDTH (8),
        .RATIO    (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_in        (din),
        .data_in_valid  (vin),
        .data_in_last   (lin),
        .data_in_ready  (irdy),
        .data_out       (dout),
        .data_out_mask  (mask),
        .data_out_last  (olast),
        .data_out_valid (ov),
        .data_out_ready (ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        o;
        logic        e_irdy;
        logic        e_ov;
        logic        cd;
        logic [31:0] e_dout;
        logic [3:0]  e_mask;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  m;
        logic        l;
    } word_t;

    vec_t  vecs[$];
    word_t exp_q[$];

    logic [7:0] m_lane[4];
    int         m_cnt;
    bit         m_ov;
    int         accepted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic r, input logic v, input logic [7:0] d,
                       input logic o, input logic er, input logic eov, input logic cd,
                       input logic [31:0] ed, input logic [3:0] em);
        vec_t t;
        t.name = n; t.r = r; t.v = v; t.d = d; t.o = o;
        t.e_irdy = er; t.e_ov = eov; t.cd = cd; t.e_dout = ed; t.e_mask = em;
        vecs.push_back(t);
    endtask

    // One randomised cycle: drive, check against the model, advance the model.
    task automatic rnd_cycle(input logic v, input logic [7:0] d, input logic l, input logic o);
        logic  m_rdy;
        bit    closed;
        word_t w;
        vin = v; din = d; lin = l; ordy = o;
        @(negedge clk);
        m_rdy = LastEn ? (!m_ov || o) : ((m_cnt != 3) || !m_ov || o);
        chk("rnd irdy", irdy, m_rdy);
        chk("rnd ov", ov, m_ov);
        if (m_ov && o && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("rnd data", dout, w.d);
            chk("rnd mask", mask, w.m);
            chk("rnd last", olast, w.l);
        end
        closed = 1'b0;
        if (v && m_rdy) begin
            accepted++;
            m_lane[m_cnt] = d;
            if (m_cnt == 3 || (LastEn && l)) begin
                for (int k = 0; k < 4; k++) begin
                    w.d[k*8 +: 8] = (k <= m_cnt) ? m_lane[k] : 8'h00;
                    w.m[k]        = (k <= m_cnt);
                end
                w.l = LastEn && l;
                exp_q.push_back(w);
                m_cnt  = 0;
                closed = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        if (closed) m_ov = 1'b1;
        else if (o) m_ov = 1'b0;
        step();
    endtask

    initial begin
        int   sent;
        logic exp_r;

        rst = 1'b1; vin = 1'b0; din = 8'h00; lin = 1'b0; ordy = 1'b1;
        step();
        step();

        // name        r  v  d      o  irdy     ov cd data          mask
        add("reset",   1, 0, 8'h00, 1, 1,       0, 1, 32'h0,        4'h0);
        add("w1 b0",   0, 1, 8'h11, 1, 1,       0, 0, 32'h0,        4'h0);
        add("w1 b1",   0, 1, 8'h22, 1, 1,       0, 0, 32'h0,        4'h0);
        add("w1 b2",   0, 1, 8'h33, 1, 1,       0, 0, 32'h0,        4'h0);
        add("w1 b3",   0, 1, 8'h44, 1, 1,       0, 0, 32'h0,        4'h0);
        add("w1 out",  0, 0, 8'h00, 1, 1,       1, 1, 32'h44332211, 4'hF);
        add("w1 gone", 0, 0, 8'h00, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c b1",    0, 1, 8'h01, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c b2",    0, 1, 8'h02, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c b3",    0, 1, 8'h03, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c b4",    0, 1, 8'h04, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c b5",    0, 1, 8'h05, 1, 1,       1, 1, 32'h04030201, 4'hF);
        add("c b6",    0, 1, 8'h06, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c b7",    0, 1, 8'h07, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c b8",    0, 1, 8'h08, 1, 1,       0, 0, 32'h0,        4'h0);
        add("c out2",  0, 0, 8'h00, 1, 1,       1, 1, 32'h08070605, 4'hF);
        add("p b1",    0, 1, 8'h09, 1, 1,       0, 0, 32'h0,        4'h0);
        add("p b2",    0, 1, 8'h0A, 1, 1,       0, 0, 32'h0,        4'h0);
        add("rst mid", 1, 0, 8'h00, 1, 1,       0, 0, 32'h0,        4'h0);
        add("r b1",    0, 1, 8'h01, 1, 1,       0, 1, 32'h0,        4'h0);
        add("r b2",    0, 1, 8'h02, 1, 1,       0, 0, 32'h0,        4'h0);
        add("r b3",    0, 1, 8'h03, 1, 1,       0, 0, 32'h0,        4'h0);
        add("r b4",    0, 1, 8'h04, 0, 1,       0, 0, 32'h0,        4'h0);
        add("pend",    0, 0, 8'h00, 0, !LastEn, 1, 1, 32'h04030201, 4'hF);
        add("rst pend",1, 0, 8'h00, 0, !LastEn, 1, 1, 32'h04030201, 4'hF);
        add("dropped", 0, 0, 8'h00, 0, 1,       0, 1, 32'h0,        4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t t;
            t = vecs[i];
            rst = t.r; vin = t.v; din = t.d; lin = 1'b0; ordy = t.o;
            @(negedge clk);
            chk({t.name, " irdy"}, irdy, t.e_irdy);
            chk({t.name, " ov"}, ov, t.e_ov);
            if (t.cd) begin
                chk({t.name, " data"}, dout, t.e_dout);
                chk({t.name, " mask"}, mask, t.e_mask);
                chk({t.name, " last"}, olast, 1'b0);
            end
            step();
        end

        // Backpressure: first word parked, further beats offered.
        rst = 1'b0; lin = 1'b0; ordy = 1'b0; vin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'(8'hB1 + i);
            step();
        end
        sent = 4;
        for (int c = 0; c < 6; c++) begin
            din = 8'(8'hB1 + sent);
            @(negedge clk);
            exp_r = LastEn ? 1'b0 : (sent < 7);
            chk("bp irdy", irdy, exp_r);
            chk("bp ov", ov, 1'b1);
            chk("bp hold", dout, 32'hB4B3B2B1);
            if (exp_r) sent++;
            step();
        end
        ordy = 1'b1;
        while (sent < 8) begin
            din = 8'(8'hB1 + sent);
            @(negedge clk);
            chk("rel irdy", irdy, 1'b1);
            sent++;
            step();
        end
        vin = 1'b0;
        @(negedge clk);
        chk("rel ov", ov, 1'b1);
        chk("rel data", dout, 32'hB8B7B6B5);
        chk("rel mask", mask, 4'hF);
        step();

`ifdef STREAM_UPSIZER_LAST_EN
        // Early closure with data_in_last.
        rst = 1'b1; step(); rst = 1'b0;
        vin = 1'b1; din = 8'hAA; lin = 1'b0; step();
        din = 8'hBB; lin = 1'b1; step();
        din = 8'hCC; lin = 1'b1;
        @(negedge clk);
        chk("el ov", ov, 1'b1);
        chk("el data", dout, 32'h0000BBAA);
        chk("el mask", mask, 4'b0011);
        chk("el last", olast, 1'b1);
        step();
        vin = 1'b0; lin = 1'b0;
        @(negedge clk);
        chk("el1 data", dout, 32'h000000CC);
        chk("el1 mask", mask, 4'b0001);
        chk("el1 last", olast, 1'b1);
        step();
        vin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'(8'hD1 + i);
            lin = (i == 3);
            step();
        end
        vin = 1'b0; lin = 1'b0;
        @(negedge clk);
        chk("el4 data", dout, 32'hD4D3D2D1);
        chk("el4 mask", mask, 4'hF);
        chk("el4 last", olast, 1'b1);
        step();
`endif

        // Randomised run against the packing model.
        rst = 1'b1; vin = 1'b0; lin = 1'b0; ordy = 1'b1;
        step();
        rst = 1'b0;
        m_cnt = 0; m_ov = 1'b0; accepted = 0;
        for (int c = 0; c < 20000 && accepted < 2000; c++) begin
            rnd_cycle($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                      $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
        end
        chk("rnd beats", accepted, 2000);
        for (int c = 0; c < 3; c++) begin
            rnd_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("rnd drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
